// File: rtl/exp5_apresenta_sequencia.sv
// Presentation control unit: walks the sequence memory from address 0 up to a
// captured limit, showing each entry on the LEDs for T_ON clocks and then blanking for T_OFF clocks.
module exp5_apresenta_sequencia #(
    parameter int T_ON  = 500,
    parameter int T_OFF = 250,
    parameter int TW    = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [3:0] limite,
    input  logic [3:0] dado_mem,
    output logic [3:0] endereco,
    output logic [3:0] leds,
    output logic       apresentando,
    output logic       pronto,
    output logic [3:0] db_estado
);

    typedef enum logic [2:0] {
        INICIAL = 3'd0,
        PREPARA = 3'd1,
        MOSTRA  = 3'd2,
        APAGA   = 3'd3,
        PROXIMO = 3'd4,
        FIM     = 3'd5
    } estado_t;

    localparam logic [TW-1:0] T_ON_LAST  = TW'(T_ON - 1);
    localparam logic [TW-1:0] T_OFF_LAST = TW'(T_OFF - 1);

    estado_t       estado_reg;
    logic [TW-1:0] timer_reg;
    logic [3:0]    limite_reg;
    logic [3:0]    endereco_reg;

    // The timer is zeroed on the same edge that leaves mostra/apaga, so each
    // visit lasts exactly its terminal count plus one clocks.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_reg   <= INICIAL;
            timer_reg    <= '0;
            limite_reg   <= '0;
            endereco_reg <= '0;
        end else begin
            case (estado_reg)
                INICIAL: begin
                    timer_reg <= '0;
                    if (iniciar) begin
                        estado_reg <= PREPARA;
                    end
                end
                PREPARA: begin
                    timer_reg    <= '0;
                    endereco_reg <= '0;
                    limite_reg   <= limite;
                    estado_reg   <= MOSTRA;
                end
                MOSTRA: begin
                    if (timer_reg == T_ON_LAST) begin
                        timer_reg  <= '0;
                        estado_reg <= APAGA;
                    end else begin
                        timer_reg <= timer_reg + TW'(1);
                    end
                end
                APAGA: begin
                    if (timer_reg == T_OFF_LAST) begin
                        timer_reg  <= '0;
                        estado_reg <= (endereco_reg == limite_reg) ? FIM : PROXIMO;
                    end else begin
                        timer_reg <= timer_reg + TW'(1);
                    end
                end
                PROXIMO: begin
                    timer_reg    <= '0;
                    endereco_reg <= endereco_reg + 4'd1;
                    estado_reg   <= MOSTRA;
                end
                FIM: begin
                    timer_reg  <= '0;
                    estado_reg <= INICIAL;
                end
                default: begin
                    timer_reg  <= '0;
                    estado_reg <= INICIAL;
                end
            endcase
        end
    end

    // Outputs decode only the state register, so they stay glitch-free Moore outputs.
    always_comb begin
        db_estado = 4'hE;
        case (estado_reg)
            INICIAL: db_estado = 4'h0;
            PREPARA: db_estado = 4'h1;
            MOSTRA:  db_estado = 4'h2;
            APAGA:   db_estado = 4'h3;
            PROXIMO: db_estado = 4'h4;
            FIM:     db_estado = 4'h5;
            default: db_estado = 4'hE;
        endcase
    end

    assign apresentando = (estado_reg != INICIAL);
    assign pronto       = (estado_reg == FIM);
    assign endereco     = endereco_reg;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_leds
            assign leds[gi] = (estado_reg == MOSTRA) & dado_mem[gi];
        end
    endgenerate

endmodule

// File: tb/tb_exp5_apresenta_sequencia.sv
// Randomized bench for exp5_apresenta_sequencia: the expected per-cycle trace of
// each presentation is built from the timing rules and compared cycle by cycle.
module tb_exp5_apresenta_sequencia;

    localparam int T_ON  = 3;
    localparam int T_OFF = 2;

    logic       clock;
    logic       reset;
    logic       iniciar;
    logic [3:0] limite;
    logic [3:0] dado_mem;
    logic [3:0] endereco;
    logic [3:0] leds;
    logic       apresentando;
    logic       pronto;
    logic [3:0] db_estado;

    logic [3:0] mem [16];
    int checks_total  = 0;
    int checks_passed = 0;

    typedef struct {
        logic [3:0] db;
        logic [3:0] leds;
        logic       apres;
        logic       pronto;
        logic [3:0] endr;
        bit         chk_endr;
    } cyc_t;

    exp5_apresenta_sequencia #(.T_ON(T_ON), .T_OFF(T_OFF), .TW(16)) dut (
        .clock        (clock),
        .reset        (reset),
        .iniciar      (iniciar),
        .limite       (limite),
        .dado_mem     (dado_mem),
        .endereco     (endereco),
        .leds         (leds),
        .apresentando (apresentando),
        .pronto       (pronto),
        .db_estado    (db_estado)
    );

    assign dado_mem = mem[endereco];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] want);
        checks_total++;
        if (got !== want) begin
            $display("FAIL %s: got %h, expected %h at t=%0t", tag, got, want, $time);
        end else begin
            checks_passed++;
        end
    endtask

    function automatic cyc_t mk(input logic [3:0] db, input logic [3:0] l, input logic ap,
                                input logic pr, input logic [3:0] en, input bit c);
        cyc_t r;
        r.db = db; r.leds = l; r.apres = ap; r.pronto = pr; r.endr = en; r.chk_endr = c;
        return r;
    endfunction

    // One presentation starting from inicial; iniciar is sampled at the next edge.
    task automatic run(input int lim, input bit hold, input bit disturb);
        cyc_t q[$];
        int n;
        n = lim + 1;
        q.push_back(mk(4'h1, 4'h0, 1'b1, 1'b0, 4'h0, 1'b0));
        for (int i = 0; i < n; i++) begin
            for (int t = 0; t < T_ON; t++)  q.push_back(mk(4'h2, mem[4'(i)], 1'b1, 1'b0, 4'(i), 1'b1));
            for (int t = 0; t < T_OFF; t++) q.push_back(mk(4'h3, 4'h0, 1'b1, 1'b0, 4'(i), 1'b1));
            if (i < n - 1) q.push_back(mk(4'h4, 4'h0, 1'b1, 1'b0, 4'(i), 1'b1));
        end
        q.push_back(mk(4'h5, 4'h0, 1'b1, 1'b1, 4'(n - 1), 1'b1));
        q.push_back(mk(4'h0, 4'h0, 1'b0, 1'b0, 4'(n - 1), 1'b1));
        $display("run limite=%0d entries=%0d hold=%0d disturb=%0d pronto_cycle=%0d",
                 lim, n, hold, disturb, q.size() - 1);
        limite  = 4'(lim);
        iniciar = 1'b1;
        for (int k = 0; k < q.size(); k++) begin
            @(posedge clock);
            #1;
            if (k >= q.size() - 2) begin
                iniciar = hold;
            end else if (k == 0) begin
                if (!hold) iniciar = 1'b0;
            end else if (disturb) begin
                iniciar = 1'($urandom_range(0, 1));
                limite  = 4'($urandom_range(0, 15));
            end
            check("db_estado", db_estado, q[k].db);
            check("leds", leds, q[k].leds);
            check("apresentando", 4'(apresentando), 4'(q[k].apres));
            check("pronto", 4'(pronto), 4'(q[k].pronto));
            if (q[k].chk_endr) check("endereco", endereco, q[k].endr);
        end
    endtask

    initial begin
        reset   = 1'b1;
        iniciar = 1'b0;
        limite  = 4'h0;
        for (int i = 0; i < 16; i++) mem[i] = 4'h0;
        #1;
        check("rst_db", db_estado, 4'h0);
        check("rst_endereco", endereco, 4'h0);
        check("rst_leds", leds, 4'h0);
        check("rst_apres", 4'(apresentando), 4'h0);
        check("rst_pronto", 4'(pronto), 4'h0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("idle_db", db_estado, 4'h0);

        // Single entry
        mem[0] = 4'b0100;
        run(0, 1'b0, 1'b0);

        // Three entries, then the same with ignored iniciar/limite changes
        mem[0] = 4'b0001; mem[1] = 4'b0010; mem[2] = 4'b1000;
        run(2, 1'b0, 1'b0);
        run(2, 1'b0, 1'b1);

        // Full range
        for (int i = 0; i < 16; i++) mem[i] = 4'(i);
        run(15, 1'b0, 1'b0);

        // Asynchronous reset during apaga of entry 1
        mem[0] = 4'b0001; mem[1] = 4'b0010; mem[2] = 4'b1000;
        limite  = 4'd2;
        iniciar = 1'b1;
        @(posedge clock);
        #1;
        iniciar = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        check("pre_rst_db", db_estado, 4'h3);
        check("pre_rst_endereco", endereco, 4'h1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_db", db_estado, 4'h0);
        check("async_rst_endereco", endereco, 4'h0);
        check("async_rst_leds", leds, 4'h0);
        check("async_rst_apres", 4'(apresentando), 4'h0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clock);
            #1;
            check("rst_hold_pronto", 4'(pronto), 4'h0);
            check("rst_hold_db", db_estado, 4'h0);
        end
        @(negedge clock);
        reset = 1'b0;
        run(2, 1'b0, 1'b0);

        // Back-to-back runs with iniciar held high
        mem[0] = 4'b1010;
        run(0, 1'b1, 1'b0);
        run(0, 1'b1, 1'b0);
        run(0, 1'b0, 1'b0);

        // Randomized runs
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 16; i++) mem[i] = 4'($urandom_range(0, 15));
            run(int'($urandom_range(0, 15)), 1'b0, 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
